// File: rtl/stash_if.sv
`default_nettype none
// ============================================================================
// stash_if : sample store bus (producer write + browse/read side)
// Rev 1.0
// ============================================================================
interface stash_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] sample_in;
    logic             sample_in_valid;
    logic             next_sample;
    logic [WIDTH-1:0] sample_out;

    modport master (
        output sample_in,
        output sample_in_valid,
        output next_sample,
        input  sample_out
    );

    modport slave (
        input  sample_in,
        input  sample_in_valid,
        input  next_sample,
        output sample_out
    );
endinterface
`default_nettype wire

// File: rtl/stash.sv
`default_nettype none
// ============================================================================
// stash : circular DEPTH x WIDTH sample store with independent browse pointer
// Rev 1.0
// ============================================================================
module stash #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 8
) (
    input  wire logic clk,
    input  wire logic reset,
    stash_if.slave    bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] C_PTR_LAST   = PW'(DEPTH - 1);
    localparam logic [CW-1:0] C_COUNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    logic w_write;
    logic w_advance;
    logic w_rd_last;

    assign w_write   = bus.sample_in_valid;
    assign w_advance = bus.next_sample && (count_q != '0);
    // Read wrap tracks the number of valid entries, not DEPTH, so a partial fill browses only what exists.
    assign w_rd_last = (CW'(rd_ptr_q) == (count_q - CW'(1)));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_write) begin
            wr_ptr_d = (wr_ptr_q == C_PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
            if (count_q != C_COUNT_FULL) begin
                count_d = count_q + CW'(1);
            end
        end
        if (w_advance) begin
            rd_ptr_d = w_rd_last ? '0 : rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_write) begin
            mem_q[wr_ptr_q] <= bus.sample_in;
        end
    end

    assign bus.sample_out = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_stash.sv
`default_nettype none
// ============================================================================
// tb_stash : directed stimulus with queue-based scoreboard for stash
// Rev 1.0
// ============================================================================
module tb_stash;
    localparam int DEPTH = 5;
    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] val;
        string            tag;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb[$];

    stash_if #(.WIDTH(WIDTH)) bus ();

    stash #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected entry consumed per falling edge, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.sample_out !== e.val) begin
                    errors++;
                    $display("FAIL %s: sample_out got %0d expected %0d", e.tag, bus.sample_out, e.val);
                end
            end
        end
    end

    task automatic tick(input logic v, input logic [WIDTH-1:0] d, input logic n);
        bus.sample_in_valid = v;
        bus.sample_in       = d;
        bus.next_sample     = n;
        @(posedge clk);
        #1;
        bus.sample_in_valid = 1'b0;
        bus.sample_in       = 8'hA5;
        bus.next_sample     = 1'b0;
    endtask

    task automatic expect_out(input logic [WIDTH-1:0] v, input string tag);
        exp_t e;
        e.val = v;
        e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        logic [WIDTH-1:0] seq3 [7];
        logic [WIDTH-1:0] seq4 [6];
        checks = 0;
        errors = 0;
        seq3 = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd10, 8'd20};
        seq4 = '{8'd30, 8'd40, 8'd50, 8'd60, 8'd20, 8'd30};

        reset               = 1'b0;
        bus.sample_in       = 8'h00;
        bus.sample_in_valid = 1'b0;
        bus.next_sample     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_out(8'd0, "reset_held");
        reset = 1'b1;
        @(posedge clk);
        #1;
        expect_out(8'd0, "after_release");

        // Advances with nothing stored must not move the read pointer.
        repeat (3) tick(1'b0, 8'h00, 1'b1);
        expect_out(8'd0, "empty_advance");
        tick(1'b0, 8'hFF, 1'b0);
        expect_out(8'd0, "garbage_no_valid_empty");

        tick(1'b1, 8'd10, 1'b0);
        expect_out(8'd10, "first_write_visible");
        tick(1'b1, 8'd20, 1'b0);
        tick(1'b1, 8'd30, 1'b0);
        tick(1'b1, 8'd40, 1'b0);
        tick(1'b1, 8'd50, 1'b0);
        tick(1'b0, 8'hFF, 1'b0);
        expect_out(8'd10, "full_garbage_ignored");

        for (int i = 0; i < 7; i++) begin
            expect_out(seq3[i], $sformatf("wrap_read_%0d", i));
            tick(1'b0, 8'h00, 1'b1);
        end

        // Read pointer now at slot 2; sixth write overwrites slot 0.
        tick(1'b1, 8'd60, 1'b0);
        for (int i = 0; i < 6; i++) begin
            expect_out(seq4[i], $sformatf("overwrite_read_%0d", i));
            if (i < 5) tick(1'b0, 8'h00, 1'b1);
        end

        // Simultaneous write to slot 1 and advance from slot 2.
        tick(1'b1, 8'd70, 1'b1);
        expect_out(8'd40, "simul_write_advance");
        repeat (3) tick(1'b0, 8'h00, 1'b1);
        expect_out(8'd70, "simul_write_landed");

        // Async reset asserted between clock edges.
        @(posedge clk);
        #2;
        reset = 1'b0;
        expect_out(8'd0, "async_reset_1");
        reset = 1'b1;
        @(posedge clk);
        #1;
        expect_out(8'd0, "post_reset_1");

        tick(1'b1, 8'd1, 1'b0);
        expect_out(8'd1, "partial_w1");
        tick(1'b1, 8'd2, 1'b0);
        expect_out(8'd1, "partial_w2");
        tick(1'b0, 8'h00, 1'b1);
        expect_out(8'd2, "partial_adv1");
        tick(1'b0, 8'h00, 1'b1);
        expect_out(8'd1, "partial_adv2_wrap");
        tick(1'b0, 8'h00, 1'b1);
        expect_out(8'd2, "partial_adv3");

        @(posedge clk);
        #2;
        reset = 1'b0;
        expect_out(8'd0, "async_reset_2");
        reset = 1'b1;
        @(posedge clk);
        #1;
        tick(1'b1, 8'd7, 1'b0);
        expect_out(8'd7, "write_after_reset");

        for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: pending %0d expected 0", sb.size());
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
